// File: rtl/sudoku_hex2bin_loader_if.sv
// Handshake bundle between a hex-digit source, the board loader and the board checker.
// The master modport drives digits and acks; the slave modport is the loader.
interface sudoku_hex2bin_loader_if #(
    parameter int CELLS = 81,
    parameter int IDX_W = 7
);
    logic               start;
    logic [3:0]         digit_in;
    logic               digit_valid;
    logic               digit_ready;
    logic [CELLS*9-1:0] board;
    logic               board_valid;
    logic               board_ack;
    logic               busy;
    logic [IDX_W-1:0]   cell_idx;
    logic [IDX_W-1:0]   given_count;
    logic               err_digit;

    modport master (
        output start, digit_in, digit_valid, board_ack,
        input  digit_ready, board, board_valid, busy, cell_idx, given_count, err_digit
    );

    modport slave (
        input  start, digit_in, digit_valid, board_ack,
        output digit_ready, board, board_valid, busy, cell_idx, given_count, err_digit
    );
endinterface

// File: rtl/sudoku_hex2bin_loader.sv
// Streams hex digits into a one-hot Sudoku board; one digit per cycle, board_valid 1 cycle after the last accept.
// Backpressure: digit_ready is high only in LOAD; the board is held in HOLD until board_ack.
module sudoku_hex2bin_loader #(
    parameter int CELLS = 81,
    parameter int IDX_W = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sudoku_hex2bin_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       accept;
    logic [8:0] onehot;
    logic       is_given;
    logic       is_illegal;

    assign accept = bus.digit_valid && bus.digit_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // start wins over every other event in every state
    always_comb begin
        state_nxt       = state;
        bus.digit_ready = 1'b0;
        bus.busy        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                bus.digit_ready = 1'b1;
                bus.busy        = 1'b1;
                if (bus.start)
                    state_nxt = LOAD;
                else if (accept && bus.cell_idx == IDX_W'(CELLS - 1))
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.start)
                    state_nxt = LOAD;
                else if (bus.board_ack)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        onehot     = '0;
        is_given   = 1'b0;
        is_illegal = 1'b0;
        if (bus.digit_in >= 4'd10) begin
            is_illegal = 1'b1;
        end else if (bus.digit_in != 4'd0) begin
            is_given = 1'b1;
            onehot   = 9'd1 << (bus.digit_in - 4'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.board       <= '0;
            bus.board_valid <= 1'b0;
            bus.cell_idx    <= '0;
            bus.given_count <= '0;
            bus.err_digit   <= 1'b0;
        end else begin
            bus.board_valid <= (state_nxt == HOLD);
            if (bus.start) begin
                bus.board       <= '0;
                bus.cell_idx    <= '0;
                bus.given_count <= '0;
                bus.err_digit   <= 1'b0;
            end else if (accept) begin
                for (int i = 0; i < CELLS; i++) begin
                    if (bus.cell_idx == IDX_W'(i))
                        bus.board[i*9 +: 9] <= onehot;
                end
                bus.cell_idx <= bus.cell_idx + IDX_W'(1);
                if (is_given)
                    bus.given_count <= bus.given_count + IDX_W'(1);
                if (is_illegal)
                    bus.err_digit <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sudoku_hex2bin_loader.sv
// Directed bench for the hex-to-one-hot board loader: digit table plus load, restart, backpressure and HOLD sequences.
module tb_sudoku_hex2bin_loader;
    localparam int CELLS = 81;
    localparam int IDX_W = 7;

    typedef struct {
        logic [3:0] d;
        logic [8:0] oh;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [3:0] dig [0:CELLS-1];
    logic [CELLS*9-1:0] snap;
    vec_t tbl [16];

    sudoku_hex2bin_loader_if #(.CELLS(CELLS), .IDX_W(IDX_W)) bus ();

    sudoku_hex2bin_loader #(.CELLS(CELLS), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    // digits from dig[], valid held high; board_valid must be low until the last accept
    task automatic load_all();
        for (int i = 0; i < CELLS; i++) begin
            bus.digit_in    = dig[i];
            bus.digit_valid = 1'b1;
            if (i == CELLS - 1) begin
                chk("bv_before_last", bus.board_valid, 0);
                chk("idx_before_last", bus.cell_idx, CELLS - 1);
            end
            step();
        end
        bus.digit_valid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_board"}, bus.board == '0, 1);
        chk({tag, "_bv"}, bus.board_valid, 0);
        chk({tag, "_rdy"}, bus.digit_ready, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_idx"}, bus.cell_idx, 0);
        chk({tag, "_given"}, bus.given_count, 0);
        chk({tag, "_err"}, bus.err_digit, 0);
    endtask

    initial begin
        int acc;
        int cyc;
        logic took;
        logic mid_seen;

        checks = 0;
        errors = 0;
        tbl[0]  = '{4'h0, 9'h000}; tbl[1]  = '{4'h1, 9'h001};
        tbl[2]  = '{4'h2, 9'h002}; tbl[3]  = '{4'h3, 9'h004};
        tbl[4]  = '{4'h4, 9'h008}; tbl[5]  = '{4'h5, 9'h010};
        tbl[6]  = '{4'h6, 9'h020}; tbl[7]  = '{4'h7, 9'h040};
        tbl[8]  = '{4'h8, 9'h080}; tbl[9]  = '{4'h9, 9'h100};
        tbl[10] = '{4'hA, 9'h000}; tbl[11] = '{4'hB, 9'h000};
        tbl[12] = '{4'hC, 9'h000}; tbl[13] = '{4'hD, 9'h000};
        tbl[14] = '{4'hE, 9'h000}; tbl[15] = '{4'hF, 9'h000};

        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.digit_in    = 4'h0;
        bus.digit_valid = 1'b0;
        bus.board_ack   = 1'b0;
        step(); step();
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        step();
        chk("idle_ready", bus.digit_ready, 0);

        // full load, cell i = (i%9)+1
        for (int i = 0; i < CELLS; i++) dig[i] = 4'((i % 9) + 1);
        do_start();
        chk("load_busy", bus.busy, 1);
        chk("load_ready", bus.digit_ready, 1);
        load_all();
        chk("full_bv", bus.board_valid, 1);
        chk("full_cell0", bus.board[8:0], 9'h001);
        chk("full_cell8", bus.board[80:72], 9'h100);
        chk("full_cell80", bus.board[728:720], 9'h100);
        chk("full_given", bus.given_count, 81);
        chk("full_err", bus.err_digit, 0);
        chk("full_idx", bus.cell_idx, 81);
        chk("hold_ready", bus.digit_ready, 0);

        // ack after 3 HOLD cycles
        snap = bus.board;
        step(); step();
        chk("hold3_bv", bus.board_valid, 1);
        bus.board_ack = 1'b1;
        step();
        bus.board_ack = 1'b0;
        chk("ack_bv", bus.board_valid, 0);
        chk("ack_busy", bus.busy, 0);
        chk("ack_board_kept", bus.board == snap, 1);
        chk("ack_given_kept", bus.given_count, 81);
        bus.board_ack = 1'b1;
        step();
        bus.board_ack = 1'b0;
        chk("idle_ack_ignored", bus.board_valid, 0);

        // empties with one illegal and one given
        for (int i = 0; i < CELLS; i++) dig[i] = 4'h0;
        dig[5] = 4'hA;
        dig[6] = 4'h3;
        do_start();
        chk("restart_cleared", bus.board == '0, 1);
        load_all();
        chk("empty_cell5", bus.board[53:45], 9'h000);
        chk("empty_cell6", bus.board[62:54], 9'h004);
        chk("empty_given", bus.given_count, 1);
        chk("empty_err", bus.err_digit, 1);
        bus.board_ack = 1'b1;
        step();
        bus.board_ack = 1'b0;

        // digit conversion table
        for (int i = 0; i < CELLS; i++) dig[i] = tbl[i % 16].d;
        do_start();
        load_all();
        for (int i = 0; i < 16; i++)
            chk($sformatf("tbl_digit_%0h", tbl[i].d), bus.board[i*9 +: 9], tbl[i].oh);
        chk("tbl_given", bus.given_count, 45);
        chk("tbl_err", bus.err_digit, 1);

        // random valid gaps, cell i = i%11, started straight from HOLD
        for (int i = 0; i < CELLS; i++) dig[i] = 4'(i % 11);
        do_start();
        chk("hold_start_bv", bus.board_valid, 0);
        acc = 0;
        cyc = 0;
        mid_seen = 1'b0;
        while (acc < CELLS && cyc < 3000) begin
            bus.digit_in    = dig[acc];
            bus.digit_valid = 1'($urandom_range(0, 1));
            took = bus.digit_valid && bus.digit_ready;
            step();
            cyc++;
            if (took) acc++;
            if (acc == 30 && !mid_seen) begin
                mid_seen = 1'b1;
                chk("bp_idx_mid", bus.cell_idx, 30);
            end
        end
        bus.digit_valid = 1'b0;
        chk("bp_timeout", acc, CELLS);
        chk("bp_bv", bus.board_valid, 1);
        chk("bp_given", bus.given_count, 66);
        chk("bp_cell10", bus.board[98:90], 9'h000);
        chk("bp_cell12", bus.board[116:108], 9'h001);
        snap = bus.board;
        bus.digit_in    = 4'h5;
        bus.digit_valid = 1'b1;
        step(); step(); step();
        bus.digit_valid = 1'b0;
        chk("bp_hold_board", bus.board == snap, 1);
        chk("bp_hold_idx", bus.cell_idx, 81);
        chk("bp_hold_given", bus.given_count, 66);
        bus.board_ack = 1'b1;
        step();
        bus.board_ack = 1'b0;

        // restart after 40 digits, with a digit on the start cycle
        do_start();
        for (int i = 0; i < 40; i++) begin
            bus.digit_in    = 4'h1;
            bus.digit_valid = 1'b1;
            step();
        end
        chk("rs_idx40", bus.cell_idx, 40);
        bus.start    = 1'b1;
        bus.digit_in = 4'h5;
        step();
        bus.start       = 1'b0;
        bus.digit_valid = 1'b0;
        chk("rs_idx0", bus.cell_idx, 0);
        chk("rs_given0", bus.given_count, 0);
        chk("rs_busy", bus.busy, 1);
        for (int i = 0; i < CELLS; i++) dig[i] = 4'h0;
        dig[0]  = 4'h7;
        dig[80] = 4'h2;
        load_all();
        chk("rs_cell0", bus.board[8:0], 9'h040);
        chk("rs_cell1", bus.board[17:9], 9'h000);
        chk("rs_cell80", bus.board[728:720], 9'h002);
        chk("rs_given", bus.given_count, 2);
        chk("rs_err", bus.err_digit, 0);

        // start and ack together in HOLD
        bus.start     = 1'b1;
        bus.board_ack = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.board_ack = 1'b0;
        chk("sa_busy", bus.busy, 1);
        chk("sa_bv", bus.board_valid, 0);
        chk("sa_board", bus.board == '0, 1);
        chk("sa_idx", bus.cell_idx, 0);

        // reset in the middle of a load
        for (int i = 0; i < 10; i++) begin
            bus.digit_in    = 4'h9;
            bus.digit_valid = 1'b1;
            step();
        end
        chk("mid_idx10", bus.cell_idx, 10);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        bus.digit_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
